addsub_sched: RTL

ADDSUB_SCHED -- requirements
Module: addsub_sched

---
 rtl/addsub_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/addsub_sched.sv
// Two-requester add/sub unit: one N-bit slice, reused SLICES times per W-bit operation.
// Define ADDSUB_SCHED_OVF_EN to add resp_ovf (signed overflow of the W-bit result).
module addsub_sched #(
   parameter int N      = 4,
   parameter int SLICES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic                req0_m,
   input  logic [N*SLICES-1:0] req0_a,
   input  logic [N*SLICES-1:0] req0_b,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic                req1_m,
   input  logic [N*SLICES-1:0] req1_a,
   input  logic [N*SLICES-1:0] req1_b,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [N*SLICES-1:0] resp_s,
   output logic                resp_cout,
`ifdef ADDSUB_SCHED_OVF_EN
   output logic                resp_ovf,
`endif
   output logic                resp_id
);

   localparam int W  = N * SLICES;
   localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic            prio;
   logic            acc, acc_id;
   logic            m_sel;
   logic [W-1:0]    a_sel, b_sel;
   logic            m_q, id_q, carry_q;
   logic [CW-1:0]   cnt;
   logic            last;
   logic [W-1:0]    a_q, b_q, s_q;
   logic [N-1:0]    a_sl, bx_sl, s_sl;
   logic            c_sl;
   logic [W+N-1:0]  s_cat;

   // Grant, ready and next state; ready is forced low while reset is held
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (req0_valid && (!req1_valid || !prio)) req0_ready = rst_n;
            else if (req1_valid)                     req1_ready = rst_n;
            if (req0_ready || req1_ready) state_nxt = RUN;
         end
         RUN:     if (last) state_nxt = DONE;
         DONE:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign acc    = req0_ready | req1_ready;
   assign acc_id = req1_ready;
   assign m_sel  = acc_id ? req1_m : req0_m;
   assign a_sel  = acc_id ? req1_a : req0_a;
   assign b_sel  = acc_id ? req1_b : req0_b;
   assign last   = (cnt == CW'(SLICES - 1));

   // Operands shift right one slice per RUN cycle, so the slice always sees the low N bits
   assign a_sl  = a_q[N-1:0];
   assign bx_sl = b_q[N-1:0] ^ {N{m_q}};

`ifdef ADDSUB_SCHED_OVF_EN
   logic [N-1:0] lo_sum;
   logic [1:0]   hi_sum;
   logic         ovf_sl, ovf_q;

   // Split at the MSB so the carry into the top bit is visible for overflow
   always_comb begin
      lo_sum = {1'b0, a_sl[N-2:0]} + {1'b0, bx_sl[N-2:0]} + {{(N-1){1'b0}}, carry_q};
      hi_sum = {1'b0, a_sl[N-1]} + {1'b0, bx_sl[N-1]} + {1'b0, lo_sum[N-1]};
      s_sl   = {hi_sum[0], lo_sum[N-2:0]};
      c_sl   = hi_sum[1];
      ovf_sl = lo_sum[N-1] ^ hi_sum[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  ovf_q <= 1'b0;
      else if (state == RUN && last) ovf_q <= ovf_sl;
   end

   assign resp_ovf = ovf_q;
`else
   logic [N:0] sum;

   always_comb begin
      sum  = {1'b0, a_sl} + {1'b0, bx_sl} + {{N{1'b0}}, carry_q};
      s_sl = sum[N-1:0];
      c_sl = sum[N];
   end
`endif

   // Result fills from the top so slice 0 ends up in the LSBs after SLICES shifts
   assign s_cat = {s_sl, s_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         prio    <= 1'b0;
         m_q     <= 1'b0;
         id_q    <= 1'b0;
         carry_q <= 1'b0;
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (acc) begin
                  m_q     <= m_sel;
                  carry_q <= m_sel;
                  a_q     <= a_sel;
                  b_q     <= b_sel;
                  id_q    <= acc_id;
                  prio    <= ~acc_id;
                  cnt     <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> N;
               b_q     <= b_q >> N;
               s_q     <= s_cat[W+N-1:N];
               carry_q <= c_sl;
               cnt     <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign resp_valid = (state == DONE);
   assign resp_s     = s_q;
   assign resp_cout  = carry_q;
   assign resp_id    = id_q;

endmodule
